main_memory_scheduler: RTL

Schedules the dual-port main memory between three requesters:
- Instruction fetch: read-only. Owns read port 0.
- Data unit: load/store. Owns read port 1 and shares the single write port.
- Program loader: write-only. Shares the write port.

A BOOT/RUN state machine gates fetch and data until the loader signals completion. Read responses are registered, giving one-cycle latency. Write-port contention is resolved round-robin. Out-of-range accesses are flagged and suppressed.

---
 rtl/main_memory_scheduler_if.sv | 60 ++++++
 rtl/main_memory_scheduler.sv | 128 ++++++++++++
 2 files changed

// File: rtl/main_memory_scheduler_if.sv
// Bus bundle between the three requesters, the main-memory ports and the scheduler.
// Handshake: a request transfers in any cycle where req & ready; requesters hold fields until then.
interface main_memory_scheduler_if #(
    parameter int AW = 32
);
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_ready;
    logic          fetch_rvalid;
    logic [31:0]   fetch_rdata;

    logic          data_req;
    logic          data_we;
    logic [AW-1:0] data_addr;
    logic [31:0]   data_wdata;
    logic          data_ready;
    logic          data_rvalid;
    logic [31:0]   data_rdata;

    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_wdata;
    logic          ld_ready;
    logic          ld_done;

    logic [31:0]   mem_raddr_0;
    logic [31:0]   mem_raddr_1;
    logic [31:0]   mem_rdata_0;
    logic [31:0]   mem_rdata_1;
    logic [31:0]   mem_waddr;
    logic [31:0]   mem_wdata;
    logic          mem_wen;

    logic          booted;
    logic          addr_err;

    modport slave (
        input  fetch_req, fetch_addr,
        output fetch_ready, fetch_rvalid, fetch_rdata,
        input  data_req, data_we, data_addr, data_wdata,
        output data_ready, data_rvalid, data_rdata,
        input  ld_req, ld_addr, ld_wdata, ld_done,
        output ld_ready,
        output mem_raddr_0, mem_raddr_1, mem_waddr, mem_wdata, mem_wen,
        input  mem_rdata_0, mem_rdata_1,
        output booted, addr_err
    );

    modport master (
        output fetch_req, fetch_addr,
        input  fetch_ready, fetch_rvalid, fetch_rdata,
        output data_req, data_we, data_addr, data_wdata,
        input  data_ready, data_rvalid, data_rdata,
        output ld_req, ld_addr, ld_wdata, ld_done,
        input  ld_ready,
        input  mem_raddr_0, mem_raddr_1, mem_waddr, mem_wdata, mem_wen,
        output mem_rdata_0, mem_rdata_1,
        input  booted, addr_err
    );
endinterface

// File: rtl/main_memory_scheduler.sv
// Dual-port main-memory scheduler: fetch on read port 0, data on read port 1,
// data/loader sharing the write port round-robin, gated by a BOOT/RUN state machine.
module main_memory_scheduler #(
    parameter int DEPTH = 2048,
    parameter int AW    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    main_memory_scheduler_if.slave  bus,
    output logic                    dbg_state_o
);
    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_e;

    state_e      state_q, state_d;
    logic        rr_q, rr_d;
    logic        fetch_rvalid_q, fetch_rvalid_d;
    logic        data_rvalid_q, data_rvalid_d;
    logic [31:0] fetch_rdata_q, fetch_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        addr_err_q, addr_err_d;

    logic        fetch_ready, data_ready, ld_ready;
    logic        contend;
    logic        f_acc, dr_acc, dw_acc, ld_acc;
    logic [31:0] mem_waddr, mem_wdata;
    logic        mem_wen;

    function automatic logic in_range(input logic [AW-1:0] a);
        return a < AW'(DEPTH);
    endfunction

    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        fetch_ready    = 1'b0;
        data_ready     = 1'b0;
        ld_ready       = 1'b1;
        mem_waddr      = '0;
        mem_wdata      = '0;
        mem_wen        = 1'b0;
        fetch_rvalid_d = 1'b0;
        data_rvalid_d  = 1'b0;
        fetch_rdata_d  = fetch_rdata_q;
        data_rdata_d   = data_rdata_q;
        addr_err_d     = addr_err_q;

        contend = (state_q == RUN) && bus.data_req && bus.data_we && bus.ld_req;

        case (state_q)
            BOOT: begin
                if (bus.ld_done) state_d = RUN;
            end
            RUN: begin
                fetch_ready = 1'b1;
                // rr_q names the contention winner: 0 = loader, 1 = data.
                data_ready  = !(contend && !rr_q);
                ld_ready    = !(contend && rr_q);
                if (contend) rr_d = ~rr_q;
            end
            default: state_d = BOOT;
        endcase

        f_acc  = bus.fetch_req && fetch_ready;
        dr_acc = bus.data_req && !bus.data_we && data_ready;
        dw_acc = bus.data_req && bus.data_we && data_ready;
        ld_acc = bus.ld_req && ld_ready;

        if (ld_acc) begin
            mem_waddr = 32'(bus.ld_addr);
            mem_wdata = bus.ld_wdata;
            mem_wen   = in_range(bus.ld_addr);
        end else if (dw_acc) begin
            mem_waddr = 32'(bus.data_addr);
            mem_wdata = bus.data_wdata;
            mem_wen   = in_range(bus.data_addr);
        end

        if (f_acc) begin
            fetch_rvalid_d = 1'b1;
            fetch_rdata_d  = in_range(bus.fetch_addr) ? bus.mem_rdata_0 : 32'h0;
        end
        if (dr_acc) begin
            data_rvalid_d = 1'b1;
            data_rdata_d  = in_range(bus.data_addr) ? bus.mem_rdata_1 : 32'h0;
        end

        if ((f_acc && !in_range(bus.fetch_addr)) ||
            ((dr_acc || dw_acc) && !in_range(bus.data_addr)) ||
            (ld_acc && !in_range(bus.ld_addr)))
            addr_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= BOOT;
            rr_q           <= 1'b0;
            fetch_rvalid_q <= 1'b0;
            data_rvalid_q  <= 1'b0;
            fetch_rdata_q  <= '0;
            data_rdata_q   <= '0;
            addr_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_q           <= rr_d;
            fetch_rvalid_q <= fetch_rvalid_d;
            data_rvalid_q  <= data_rvalid_d;
            fetch_rdata_q  <= fetch_rdata_d;
            data_rdata_q   <= data_rdata_d;
            addr_err_q     <= addr_err_d;
        end
    end

    assign bus.fetch_ready  = fetch_ready;
    assign bus.fetch_rvalid = fetch_rvalid_q;
    assign bus.fetch_rdata  = fetch_rdata_q;
    assign bus.data_ready   = data_ready;
    assign bus.data_rvalid  = data_rvalid_q;
    assign bus.data_rdata   = data_rdata_q;
    assign bus.ld_ready     = ld_ready;
    assign bus.mem_raddr_0  = 32'(bus.fetch_addr);
    assign bus.mem_raddr_1  = 32'(bus.data_addr);
    assign bus.mem_waddr    = mem_waddr;
    assign bus.mem_wdata    = mem_wdata;
    assign bus.mem_wen      = mem_wen;
    assign bus.booted       = (state_q == RUN);
    assign bus.addr_err     = addr_err_q;
    assign dbg_state_o      = state_q;
endmodule
